// File: rtl/mem_arbiter.sv
// Arbiter sharing one fixed-latency single-ported memory between fetch (IF) and data (DM) ports.
// DM wins ties unless IF has been passed over STARVE_MAX times in a row.
module mem_arbiter #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        dm_rd,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        err
);

  localparam logic [3:0] LatCnt    = 4'(LATENCY);
  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StIBusy, StDBusy} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  starve_q, starve_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] dm_rdata_q, dm_rdata_d;
  logic        if_done_q, if_done_d;
  logic        dm_done_q, dm_done_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_wr_q, mem_wr_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        err_q, err_d;
  logic        eff_if, eff_dm;

  // Done masks keep a still-held request from being re-granted in its own done cycle.
  assign eff_if = if_req & ~if_done_q;
  assign eff_dm = (dm_rd ^ dm_wr) & ~dm_done_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    mem_en_d    = 1'b0;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (dm_rd && dm_wr) begin
          err_d = 1'b1;
        end
        if (eff_dm && (!eff_if || (starve_q < StarveMax))) begin
          state_d     = StDBusy;
          cnt_d       = LatCnt;
          mem_en_d    = 1'b1;
          mem_wr_d    = dm_wr;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (eff_if && (starve_q < StarveMax)) begin
            starve_d = starve_q + 4'd1;
          end
        end else if (eff_if) begin
          state_d    = StIBusy;
          cnt_d      = LatCnt;
          mem_en_d   = 1'b1;
          mem_wr_d   = 1'b0;
          mem_addr_d = if_addr;
          starve_d   = 4'd0;
        end
      end
      StIBusy, StDBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StIdle;
          if (state_q == StIBusy) begin
            if_rdata_d = mem_rdata;
            if_done_d  = 1'b1;
          end else begin
            dm_done_d = 1'b1;
            if (!mem_wr_q) begin
              dm_rdata_d = mem_rdata;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      starve_q    <= 4'd0;
      if_rdata_q  <= 16'd0;
      dm_rdata_q  <= 16'd0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 16'd0;
      mem_wdata_q <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_done   = dm_done_q;
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign if_stall  = if_req & ~if_done_q;
  assign dm_stall  = (dm_rd | dm_wr) & ~dm_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a combinational-read memory model indexed by mem_addr.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        dm_rd;
  logic        dm_wr;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata;
  logic        dm_done;
  logic        dm_stall;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        err;

  int n_chk;
  int n_bad;
  logic [15:0] mem [256];

  mem_arbiter #(
    .LATENCY   (2),
    .STARVE_MAX(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_done  (if_done),
    .if_stall (if_stall),
    .dm_rd    (dm_rd),
    .dm_wr    (dm_wr),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_done  (dm_done),
    .dm_stall (dm_stall),
    .mem_en   (mem_en),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_en && mem_wr) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant pattern used by the starvation check: IF drops only in DM done cycles.
  task automatic run_starve(input string tag);
    int     n_gr;
    logic   reassert;
    logic   fin;
    logic [3:0] kinds;
    n_gr     = 0;
    reassert = 1'b0;
    fin      = 1'b0;
    kinds    = 4'b0;
    if_req   = 1'b1;
    if_addr  = 16'h0010;
    dm_rd    = 1'b1;
    dm_addr  = 16'h0200;
    for (int c = 0; c < 60 && !fin; c++) begin
      tick();
      if (mem_en) begin
        if (n_gr < 4) kinds[n_gr] = (mem_addr == 16'h0010);
        n_gr++;
      end
      if (reassert) begin
        if_req   = 1'b1;
        reassert = 1'b0;
      end
      if (dm_done) begin
        if_req   = 1'b0;
        reassert = 1'b1;
      end
      if (if_done) begin
        if_req = 1'b0;
        dm_rd  = 1'b0;
        fin    = 1'b1;
      end
    end
    check_eq({tag, "_finished"}, 32'(fin), 32'd1);
    check_eq({tag, "_grants"}, n_gr, 4);
    check_eq({tag, "_order"}, 32'(kinds), 32'b1000);
  endtask

  initial begin
    n_chk    = 0;
    n_bad    = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'hA5A5;
    mem[8'h00] = 16'h1234;
    rst      = 1'b0;
    if_req   = 1'b0;
    if_addr  = 16'h0000;
    dm_rd    = 1'b0;
    dm_wr    = 1'b0;
    dm_addr  = 16'h0000;
    dm_wdata = 16'h0000;
    tick();
    tick();
    check_eq("reset_outs", {mem_en, mem_wr, if_done, dm_done, err, if_stall, dm_stall}, 32'd0);
    check_eq("reset_addr", {mem_addr, mem_wdata}, 32'd0);
    check_eq("reset_rdata", {if_rdata, dm_rdata}, 32'd0);

    // 1: single fetch
    rst     = 1'b1;
    if_req  = 1'b1;
    if_addr = 16'h0010;
    #1;
    check_eq("t1_stall_c0", 32'(if_stall), 32'd1);
    tick();
    check_eq("t1_c1_en_wr", {mem_en, mem_wr}, 32'b10);
    check_eq("t1_c1_addr", mem_addr, 32'h0010);
    check_eq("t1_c1_stall", {if_stall, if_done}, 32'b10);
    tick();
    check_eq("t1_c2", {mem_en, if_stall, if_done}, 32'b010);
    tick();
    check_eq("t1_c3_done", {if_done, if_stall}, 32'b10);
    check_eq("t1_c3_rdata", if_rdata, 32'hA5A5);
    if_req = 1'b0;
    tick();
    check_eq("t1_c4_pulse", {if_done, mem_en}, 32'b00);

    // 2: simultaneous IF and DM read
    if_req  = 1'b1;
    dm_rd   = 1'b1;
    dm_addr = 16'h0200;
    tick();
    check_eq("t2_dm_grant", {mem_en, mem_addr}, {15'd0, 1'b1, 16'h0200});
    tick();
    tick();
    check_eq("t2_dm_done", {dm_done, if_done}, 32'b10);
    check_eq("t2_dm_rdata", dm_rdata, 32'h1234);
    dm_rd = 1'b0;
    tick();
    check_eq("t2_if_grant", {mem_en, mem_addr}, {15'd0, 1'b1, 16'h0010});
    tick();
    check_eq("t2_if_wait", {if_done, dm_done}, 32'b00);
    tick();
    check_eq("t2_if_done", {if_done, if_rdata}, {15'd0, 1'b1, 16'hA5A5});
    if_req = 1'b0;
    tick();

    // 3: DM write keeps dm_rdata
    dm_wr    = 1'b1;
    dm_addr  = 16'h0044;
    dm_wdata = 16'hBEEF;
    tick();
    check_eq("t3_c1", {mem_en, mem_wr, mem_wdata}, {14'd0, 2'b11, 16'hBEEF});
    check_eq("t3_c1_addr", mem_addr, 32'h0044);
    tick();
    check_eq("t3_c2", {mem_en, mem_wr, mem_wdata, dm_done}, {13'd0, 2'b01, 16'hBEEF, 1'b0});
    tick();
    check_eq("t3_done", {dm_done, mem_wr}, 32'b11);
    check_eq("t3_rdata_kept", dm_rdata, 32'h1234);
    check_eq("t3_mem_written", mem[8'h44], 32'hBEEF);
    dm_wr = 1'b0;
    tick();
    check_eq("t3_hold", {dm_done, mem_wr, mem_addr}, {14'd0, 2'b01, 16'h0044});

    // 4: starvation limit, twice to show the counter was cleared by the IF grant
    run_starve("t4a");
    tick();
    run_starve("t4b");
    tick();

    // 5: conflicting DM read and write
    check_eq("t5_err_before", 32'(err), 32'd0);
    dm_rd = 1'b1;
    dm_wr = 1'b1;
    tick();
    check_eq("t5_c1", {mem_en, err}, 32'b01);
    dm_rd = 1'b0;
    dm_wr = 1'b0;
    tick();
    check_eq("t5_c2", {mem_en, err}, 32'b01);
    tick();
    check_eq("t5_sticky", 32'(err), 32'd1);

    // 6: reset in the middle of a fetch
    if_req  = 1'b1;
    if_addr = 16'h0010;
    tick();
    check_eq("t6_granted", 32'(mem_en), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("t6_rst_ctl", {mem_en, mem_wr, if_done, dm_done, err}, 32'd0);
    check_eq("t6_rst_addr", {mem_addr, mem_wdata}, 32'd0);
    check_eq("t6_rst_rdata", {if_rdata, dm_rdata}, 32'd0);
    if_req = 1'b0;
    tick();
    rst = 1'b1;
    begin
      int spurious;
      spurious = 0;
      for (int c = 0; c < 6; c++) begin
        tick();
        if (if_done || mem_en) spurious++;
      end
      check_eq("t6_no_done", spurious, 0);
    end
    if_req = 1'b1;
    begin
      int waited;
      waited = 0;
      while (!if_done && waited < 20) begin
        tick();
        waited++;
      end
      check_eq("t6_fresh_lat", waited, 3);
      check_eq("t6_fresh_rdata", if_rdata, 32'hA5A5);
    end
    if_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
